tcp_rx_hdr_parser: RTL and testbench

- Receive-side TCP header extractor feeding the per-socket TCP entry FSM.
- Consumes the TCP segment as a 16-bit big-endian word stream from the IPv4 receive stage.
- Extracts ports, seq, ack, data offset and flags, and matches them against one socket tuple.
- Pulses a single-cycle valid header event, then forwards the payload after any TCP options.

---
 rtl/tcp_rx_hdr_parser.sv | 202 ++++++++++++++++++++
 tb/tb_tcp_rx_hdr_parser.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_rx_hdr_parser.sv
// tcp_rx_hdr_parser
// Receive-side TCP header extractor. Walks the 16-bit big-endian segment
// stream, latches ports/seq/ack/offset/flags, matches the segment against a
// single socket tuple, emits a one-cycle header event for matching segments,
// then forwards the payload that follows any TCP options.
module tcp_rx_hdr_parser #(
    parameter int IP_W   = 32,
    parameter int PORT_W = 16,
    parameter int SEQ_W  = 32,
    parameter int FLAG_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cfg_v_i,
    input  logic [IP_W-1:0]   cfg_ip_remote_i,
    input  logic [PORT_W-1:0] cfg_port_remote_i,
    input  logic [PORT_W-1:0] cfg_port_local_i,
    input  logic [IP_W-1:0]   ip_src_i,
    input  logic              data_v_i,
    input  logic              start_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              cancel_i,
    output logic              rec_v_o,
    output logic [SEQ_W-1:0]  rec_seq_o,
    output logic [SEQ_W-1:0]  rec_ack_o,
    output logic [FLAG_W-1:0] rec_flag_o,
    output logic              pay_v_o,
    output logic [DATA_W-1:0] pay_data_o,
    output logic              pay_last_o,
    output logic              drop_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_OPT  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]        r_state;
    logic [4:0]        r_wcnt;
    logic              r_match;
    logic [3:0]        r_doff;
    logic [SEQ_W-1:0]  r_seq;
    logic [SEQ_W-1:0]  r_ack;
    logic [FLAG_W-1:0] r_flag;

    logic              r_rec_v;
    logic [SEQ_W-1:0]  r_rec_seq;
    logic [SEQ_W-1:0]  r_rec_ack;
    logic [FLAG_W-1:0] r_rec_flag;
    logic              r_pay_v;
    logic [DATA_W-1:0] r_pay_data;
    logic              r_pay_last;
    logic              r_drop;

    logic              w_tuple_ok;
    logic [4:0]        w_opt_end;
    logic [4:0]        w_wcnt_inc;
    logic [FLAG_W-1:0] w_flag;

    // Tuple terms that do not come from the stream itself
    assign w_tuple_ok = cfg_v_i & (ip_src_i == cfg_ip_remote_i);
    // Index of the last option word (header is 2*doff words)
    assign w_opt_end  = {r_doff, 1'b0} - 5'd1;
    assign w_wcnt_inc = (r_wcnt == 5'd31) ? r_wcnt : r_wcnt + 5'd1;

    // Wire flag byte is MSB-first (FIN at bit 7 of the output vector)
    always_comb begin
        w_flag = '0;
        for (int i = 0; i < FLAG_W; i++) w_flag[i] = data_i[FLAG_W-1-i];
    end

    // Parser state, header capture and registered outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_match    <= 1'b0;
            r_doff     <= '0;
            r_seq      <= '0;
            r_ack      <= '0;
            r_flag     <= '0;
            r_rec_v    <= 1'b0;
            r_rec_seq  <= '0;
            r_rec_ack  <= '0;
            r_rec_flag <= '0;
            r_pay_v    <= 1'b0;
            r_pay_data <= '0;
            r_pay_last <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_rec_v    <= 1'b0;
            r_drop     <= 1'b0;
            r_pay_v    <= 1'b0;
            r_pay_last <= 1'b0;
            if (cancel_i) begin
                // Abort wins over any word arriving this cycle
                if (r_state != S_IDLE) r_drop <= 1'b1;
                r_state <= S_IDLE;
                r_wcnt  <= '0;
            end else if (data_v_i && start_i) begin
                // A new segment always restarts the parse; abandon any old one
                if (r_state != S_IDLE) r_drop <= 1'b1;
                r_match <= w_tuple_ok && (data_i == cfg_port_remote_i);
                if (last_i) begin
                    r_drop  <= 1'b1;
                    r_state <= S_IDLE;
                    r_wcnt  <= '0;
                end else begin
                    r_state <= S_HDR;
                    r_wcnt  <= 5'd1;
                end
            end else if (data_v_i) begin
                case (r_state)
                    S_HDR: begin
                        r_wcnt <= w_wcnt_inc;
                        case (r_wcnt)
                            5'd1: r_match <= r_match && w_tuple_ok &&
                                             (data_i == cfg_port_local_i);
                            5'd2: r_seq[SEQ_W-1:DATA_W] <= data_i;
                            5'd3: r_seq[DATA_W-1:0]     <= data_i;
                            5'd4: r_ack[SEQ_W-1:DATA_W] <= data_i;
                            5'd5: r_ack[DATA_W-1:0]     <= data_i;
                            5'd6: begin
                                r_doff <= data_i[15:12];
                                r_flag <= w_flag;
                            end
                            default: ;
                        endcase
                        if (r_wcnt == 5'd6 && data_i[15:12] < 4'd5) begin
                            r_drop  <= 1'b1;
                            r_state <= last_i ? S_IDLE : S_DROP;
                            if (last_i) r_wcnt <= '0;
                        end else if (r_wcnt == 5'd9) begin
                            if (r_match) begin
                                r_rec_v    <= 1'b1;
                                r_rec_seq  <= r_seq;
                                r_rec_ack  <= r_ack;
                                r_rec_flag <= r_flag;
                                if (last_i) begin
                                    r_state <= S_IDLE;
                                    r_wcnt  <= '0;
                                end else if (r_doff == 4'd5) begin
                                    r_state <= S_PAY;
                                end else begin
                                    r_state <= S_OPT;
                                end
                            end else begin
                                r_drop  <= 1'b1;
                                r_state <= last_i ? S_IDLE : S_DROP;
                                if (last_i) r_wcnt <= '0;
                            end
                        end else if (last_i) begin
                            // Segment ended before the fixed header completed
                            r_drop  <= 1'b1;
                            r_state <= S_IDLE;
                            r_wcnt  <= '0;
                        end
                    end
                    S_OPT: begin
                        r_wcnt <= w_wcnt_inc;
                        if (last_i) begin
                            r_state <= S_IDLE;
                            r_wcnt  <= '0;
                        end else if (r_wcnt == w_opt_end) begin
                            r_state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        r_pay_v    <= 1'b1;
                        r_pay_data <= data_i;
                        r_pay_last <= last_i;
                        if (last_i) begin
                            r_state <= S_IDLE;
                            r_wcnt  <= '0;
                        end
                    end
                    S_DROP: begin
                        if (last_i) begin
                            r_state <= S_IDLE;
                            r_wcnt  <= '0;
                        end
                    end
                    S_IDLE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rec_v_o    = r_rec_v;
    assign rec_seq_o  = r_rec_seq;
    assign rec_ack_o  = r_rec_ack;
    assign rec_flag_o = r_rec_flag;
    assign pay_v_o    = r_pay_v;
    assign pay_data_o = r_pay_data;
    assign pay_last_o = r_pay_last;
    assign drop_o     = r_drop;

endmodule

// File: tb/tb_tcp_rx_hdr_parser.sv
// tb_tcp_rx_hdr_parser
// Directed and randomized segments; expected events come from a per-segment
// model applying the header/offset/match/cancel rules to the whole word list.
module tb_tcp_rx_hdr_parser;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cfg_v_i = 1'b0;
    logic [31:0] cfg_ip_remote_i = '0;
    logic [15:0] cfg_port_remote_i = '0;
    logic [15:0] cfg_port_local_i = '0;
    logic [31:0] ip_src_i = '0;
    logic        data_v_i = 1'b0;
    logic        start_i = 1'b0;
    logic        last_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        cancel_i = 1'b0;
    logic        rec_v_o;
    logic [31:0] rec_seq_o;
    logic [31:0] rec_ack_o;
    logic [7:0]  rec_flag_o;
    logic        pay_v_o;
    logic [15:0] pay_data_o;
    logic        pay_last_o;
    logic        drop_o;

    always #5 clk = ~clk;

    tcp_rx_hdr_parser dut (
        .clk(clk), .nreset(nreset),
        .cfg_v_i(cfg_v_i), .cfg_ip_remote_i(cfg_ip_remote_i),
        .cfg_port_remote_i(cfg_port_remote_i), .cfg_port_local_i(cfg_port_local_i),
        .ip_src_i(ip_src_i), .data_v_i(data_v_i), .start_i(start_i),
        .last_i(last_i), .data_i(data_i), .cancel_i(cancel_i),
        .rec_v_o(rec_v_o), .rec_seq_o(rec_seq_o), .rec_ack_o(rec_ack_o),
        .rec_flag_o(rec_flag_o), .pay_v_o(pay_v_o), .pay_data_o(pay_data_o),
        .pay_last_o(pay_last_o), .drop_o(drop_o)
    );

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int acc = 0;
    int w6_cyc = 0;
    int w9_cyc = 0;

    // observed events
    logic [31:0] m_seq[$];
    logic [31:0] m_ack[$];
    logic [7:0]  m_flag[$];
    int          m_rec_cyc[$];
    logic [15:0] m_pay[$];
    logic        m_last[$];
    int          m_drops = 0;
    int          m_drop_cyc = 0;

    // expected events
    bit          e_rec;
    logic [31:0] e_seq;
    logic [31:0] e_ack;
    logic [7:0]  e_flag;
    logic [15:0] e_pay[$];
    logic        e_last[$];
    int          e_drops;

    logic [15:0] seg[$];

    always @(negedge clk) begin
        ncyc++;
        if (rec_v_o) begin
            m_seq.push_back(rec_seq_o);
            m_ack.push_back(rec_ack_o);
            m_flag.push_back(rec_flag_o);
            m_rec_cyc.push_back(ncyc);
        end
        if (pay_v_o) begin
            m_pay.push_back(pay_data_o);
            m_last.push_back(pay_last_o);
        end
        if (drop_o) begin
            m_drops++;
            m_drop_cyc = ncyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        m_seq.delete(); m_ack.delete(); m_flag.delete(); m_rec_cyc.delete();
        m_pay.delete(); m_last.delete();
        m_drops = 0;
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [15:0] d, input logic st, input logic lst, input logic can);
        data_v_i = 1'b1; data_i = d; start_i = st; last_i = lst; cancel_i = can;
        @(posedge clk);
        acc = ncyc;
        #1;
        data_v_i = 1'b0; data_i = '0; start_i = 1'b0; last_i = 1'b0; cancel_i = 1'b0;
    endtask

    task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [31:0] sq,
                         input logic [31:0] ak, input logic [15:0] w6, input int npay);
        int doff = int'(w6[15:12]);
        seg.delete();
        seg.push_back(sp);         seg.push_back(dp);
        seg.push_back(sq[31:16]);  seg.push_back(sq[15:0]);
        seg.push_back(ak[31:16]);  seg.push_back(ak[15:0]);
        seg.push_back(w6);         seg.push_back(16'hFFFF);
        seg.push_back(16'($urandom)); seg.push_back(16'h0000);
        if (doff > 5)
            for (int k = 0; k < 2 * (doff - 5); k++) seg.push_back(16'($urandom));
        for (int k = 0; k < npay; k++) seg.push_back(16'($urandom));
    endtask

    task automatic send_seg(input int cancel_at, input int gapmax);
        for (int i = 0; i < seg.size(); i++) begin
            if (i == cancel_at) begin
                send(seg[i], 1'b0, 1'b0, 1'b1);
                return;
            end
            send(seg[i], i == 0, i == seg.size() - 1, 1'b0);
            if (i == 6) w6_cyc = acc;
            if (i == 9) w9_cyc = acc;
            settle($urandom_range(0, gapmax));
        end
    endtask

    // Segment-level reference: which events a whole segment must produce
    task automatic model(input int cancel_at);
        int n, avail, doff;
        bit bad, matched, cancel;
        logic [15:0] w6;
        n = seg.size();
        cancel = (cancel_at >= 1) && (cancel_at < n);
        avail = cancel ? cancel_at : n;
        w6 = (avail >= 7) ? seg[6] : 16'h0;
        doff = int'(w6[15:12]);
        bad = (avail >= 7) && (doff < 5);
        e_rec = 1'b0; e_drops = 0;
        e_pay.delete(); e_last.delete();
        if (bad) begin
            e_drops++;
        end else if (avail < 10) begin
            if (!cancel) e_drops++;
        end else begin
            matched = cfg_v_i && (ip_src_i == cfg_ip_remote_i) &&
                      (seg[0] == cfg_port_remote_i) && (seg[1] == cfg_port_local_i);
            if (!matched) begin
                e_drops++;
            end else begin
                e_rec = 1'b1;
                e_seq = {seg[2], seg[3]};
                e_ack = {seg[4], seg[5]};
                for (int i = 0; i < 8; i++) e_flag[i] = w6[7-i];
                for (int k = 2 * doff; k < avail; k++) begin
                    e_pay.push_back(seg[k]);
                    e_last.push_back(!cancel && (k == n - 1));
                end
            end
        end
        if (cancel) e_drops++;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".drops"}, 64'(m_drops), 64'(e_drops));
        chk({tag, ".rec_n"}, 64'(m_seq.size()), 64'(e_rec));
        if (e_rec && m_seq.size() == 1) begin
            chk({tag, ".seq"}, 64'(m_seq[0]), 64'(e_seq));
            chk({tag, ".ack"}, 64'(m_ack[0]), 64'(e_ack));
            chk({tag, ".flag"}, 64'(m_flag[0]), 64'(e_flag));
        end
        chk({tag, ".pay_n"}, 64'(m_pay.size()), 64'(e_pay.size()));
        for (int k = 0; k < e_pay.size() && k < m_pay.size(); k++) begin
            chk({tag, ".pay_data"}, 64'(m_pay[k]), 64'(e_pay[k]));
            chk({tag, ".pay_last"}, 64'(m_last[k]), 64'(e_last[k]));
        end
    endtask

    task automatic run_seg(input string tag, input int cancel_at, input int gapmax);
        model(cancel_at);
        send_seg(cancel_at, gapmax);
        settle(3);
        compare(tag);
    endtask

    initial begin
        logic [31:0] held_seq;
        logic [15:0] sp, dp, w6;
        int doff, npay, cut, can;

        settle(2);
        chk("reset.rec_v", 64'(rec_v_o), 64'h0);
        chk("reset.rec_seq", 64'(rec_seq_o), 64'h0);
        chk("reset.rec_ack", 64'(rec_ack_o), 64'h0);
        chk("reset.rec_flag", 64'(rec_flag_o), 64'h0);
        chk("reset.pay_v", 64'(pay_v_o), 64'h0);
        chk("reset.pay_data", 64'(pay_data_o), 64'h0);
        chk("reset.pay_last", 64'(pay_last_o), 64'h0);
        chk("reset.drop", 64'(drop_o), 64'h0);

        nreset = 1'b1;
        cfg_v_i = 1'b1;
        cfg_ip_remote_i = 32'h0A000001;
        cfg_port_remote_i = 16'h1F90;
        cfg_port_local_i = 16'hC000;
        ip_src_i = 32'h0A000001;
        settle(2);
        clear_mon();

        // matched SYN+ACK, no options, no payload
        build(16'h1F90, 16'hC000, 32'h12345678, 32'h00000101, 16'h5012, 0);
        run_seg("synack", -1, 0);
        chk("synack.flag_const", 64'(rec_flag_o), 64'h48);
        if (m_rec_cyc.size() > 0) chk("synack.latency", 64'(m_rec_cyc[0]), 64'(w9_cyc + 1));
        clear_mon();

        // options then payload
        build(16'h1F90, 16'hC000, 32'hCAFEF00D, 32'h00A0B0C0, 16'h7018, 3);
        seg[seg.size()-3] = 16'hAAAA;
        seg[seg.size()-2] = 16'hBBBB;
        seg[seg.size()-1] = 16'hCCCC;
        run_seg("opts", -1, 1);
        chk("opts.pay_n_const", 64'(m_pay.size()), 64'd3);
        if (m_pay.size() == 3) chk("opts.last_word", 64'(m_pay[2]), 64'hCCCC);
        held_seq = 32'hCAFEF00D;
        clear_mon();

        // destination port mismatch, trailing words ignored
        build(16'h1F90, 16'hC001, 32'h1, 32'h2, 16'h5010, 3);
        run_seg("mismatch", -1, 0);
        chk("mismatch.drop_lat", 64'(m_drop_cyc), 64'(w9_cyc + 1));
        chk("mismatch.seq_held", 64'(rec_seq_o), 64'(held_seq));
        clear_mon();

        // bad data offset
        build(16'h1F90, 16'hC000, 32'h3, 32'h4, 16'h4010, 2);
        run_seg("badoff", -1, 0);
        chk("badoff.drop_lat", 64'(m_drop_cyc), 64'(w6_cyc + 1));
        clear_mon();

        // truncated at w4
        build(16'h1F90, 16'hC000, 32'h5, 32'h6, 16'h5010, 0);
        while (seg.size() > 5) void'(seg.pop_back());
        run_seg("trunc", -1, 0);
        clear_mon();

        // cancel on w8, then a clean segment
        build(16'h1F90, 16'hC000, 32'h7, 32'h8, 16'h5010, 0);
        run_seg("cancel", 8, 0);
        clear_mon();
        build(16'h1F90, 16'hC000, 32'h89ABCDEF, 32'h01234567, 16'h6011, 2);
        run_seg("post_cancel", -1, 0);
        clear_mon();

        // reset in the middle of payload
        build(16'h1F90, 16'hC000, 32'h9, 32'hA, 16'h5018, 6);
        for (int i = 0; i < 12; i++) send(seg[i], i == 0, 1'b0, 1'b0);
        nreset = 1'b0;
        send(seg[12], 1'b0, 1'b0, 1'b0);
        chk("rstpay.pay_v", 64'(pay_v_o), 64'h0);
        chk("rstpay.pay_data", 64'(pay_data_o), 64'h0);
        chk("rstpay.rec_seq", 64'(rec_seq_o), 64'h0);
        chk("rstpay.drop", 64'(drop_o), 64'h0);
        nreset = 1'b1;
        clear_mon();
        for (int i = 13; i < 16; i++) send(seg[i], 1'b0, i == 15, 1'b0);
        settle(3);
        chk("rstpay.ignored_pay", 64'(m_pay.size()), 64'h0);
        chk("rstpay.ignored_drop", 64'(m_drops), 64'h0);
        chk("rstpay.ignored_rec", 64'(m_seq.size()), 64'h0);
        clear_mon();
        build(16'h1F90, 16'hC000, 32'hB, 32'hC, 16'h5010, 2);
        run_seg("post_reset", -1, 0);
        clear_mon();

        // randomized segments
        for (int it = 0; it < 40; it++) begin
            cfg_v_i = ($urandom_range(0, 9) != 0);
            ip_src_i = ($urandom_range(0, 7) == 0) ? (cfg_ip_remote_i ^ 32'h1) : cfg_ip_remote_i;
            sp = ($urandom_range(0, 7) == 0) ? 16'h1F91 : 16'h1F90;
            dp = ($urandom_range(0, 7) == 0) ? 16'hC002 : 16'hC000;
            doff = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 8));
            w6 = {4'(doff), 4'h0, 8'($urandom)};
            npay = $urandom_range(0, 5);
            build(sp, dp, $urandom, $urandom, w6, npay);
            if ($urandom_range(0, 5) == 0) begin
                cut = $urandom_range(1, seg.size());
                while (seg.size() > cut) void'(seg.pop_back());
            end
            can = ($urandom_range(0, 5) == 0 && seg.size() > 1) ? int'($urandom_range(1, seg.size() - 1)) : -1;
            run_seg("rand", can, 2);
            clear_mon();
            settle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
